// File: rtl/dds_bb_feeder.sv
// Baseband sample source for the DDS up-converter: a stream-fed FIFO whose
// samples are replayed onto bb_data_o at a programmable period.
module dds_bb_feeder #(
  parameter int BB_DATA_WIDTH  = 8,
  parameter int FIFO_AW        = 4,
  parameter int HOLD_WIDTH     = 16,
  parameter int UNDERFLOW_HOLD = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [BB_DATA_WIDTH-1:0] s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     enable_i,
  input  logic [HOLD_WIDTH-1:0]    hold_cycles_i,
  output logic [BB_DATA_WIDTH-1:0] bb_data_o,
  output logic                     sample_strobe_o,
  output logic [FIFO_AW:0]         fifo_level_o,
  output logic                     underflow_o,
  input  logic                     underflow_clr_i
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [BB_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]         level_q, level_d;
  state_e                   state_q, state_d;
  logic [HOLD_WIDTH-1:0]    cnt_q, cnt_d;
  logic [BB_DATA_WIDTH-1:0] bb_q, bb_d;
  logic [BB_DATA_WIDTH-1:0] last_q, last_d;
  logic                     strobe_q, strobe_d;
  logic                     uf_q, uf_d;
  logic                     push, pop, empty, boundary;

  // Ready depends only on the registered level, so a same-cycle pop never
  // opens the input; a full FIFO takes its next sample one cycle after the pop.
  assign empty     = (level_q == '0);
  assign s_ready_o = (level_q != FULL_LEVEL) && !rst_i;
  assign push      = s_valid_i && s_ready_o;
  assign boundary  = (state_q == RUN) && enable_i && (cnt_q == '0);
  assign pop       = boundary && !empty;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bb_d     = bb_q;
    last_d   = last_q;
    strobe_d = 1'b0;
    uf_d     = uf_q;
    if (underflow_clr_i) uf_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bb_d  = '0;
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          bb_d    = '0;
        end else if (boundary) begin
          cnt_d = hold_cycles_i;
          if (!empty) begin
            bb_d     = mem_q[rd_ptr_q];
            last_d   = mem_q[rd_ptr_q];
            strobe_d = 1'b1;
          end else begin
            // Placed after the clear so a simultaneous set wins.
            uf_d = 1'b1;
            bb_d = (UNDERFLOW_HOLD != 0) ? last_q : '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the sample storage has no reset; the pointers and level define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bb_q     <= '0;
      last_q   <= '0;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bb_q     <= bb_d;
      last_q   <= last_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
    end
  end

  assign bb_data_o       = bb_q;
  assign sample_strobe_o = strobe_q;
  assign fifo_level_o    = level_q;
  assign underflow_o     = uf_q;

endmodule

// File: doc/dds_bb_feeder.md
Name: dds_bb_feeder

Overview:
- Baseband sample source that sits directly upstream of the DDS up-converter and drives its bb_data_i input.
- Accepts unsigned baseband samples over a valid/ready stream and buffers them in a FIFO.
- Presents each sample to the DDS for a programmable number of clock cycles, giving a fixed symbol/sample period.
- Flags underflow when the FIFO runs dry at a sample boundary.

Parameters:
BB_DATA_WIDTH, 8, baseband sample width; equals the DDS bb_data_i width.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.
HOLD_WIDTH, 16, width of the hold-period programming input.
UNDERFLOW_HOLD, 0, underflow output policy: 0 = output zero, 1 = repeat last sample.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
s_data_i  in  BB_DATA_WIDTH  input sample.
s_valid_i  in  1  input sample valid.
s_ready_o  out  1  FIFO can accept a sample.
enable_i  in  1  run/stop playout.
hold_cycles_i  in  HOLD_WIDTH  sample period minus 1, in clocks.
bb_data_o  out  BB_DATA_WIDTH  registered sample to the DDS bb_data_i.
sample_strobe_o  out  1  one-cycle pulse when bb_data_o takes a new value at a boundary.
fifo_level_o  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
underflow_o  out  1  sticky underflow flag.
underflow_clr_i  in  1  clears underflow_o.

Behaviour:
- Reset (async, rst_i high): FIFO empty; fifo_level_o=0; bb_data_o=0; sample_strobe_o=0; underflow_o=0; state IDLE; hold counter=0; last-sample register=0.
- s_ready_o = (level != 2**FIFO_AW) and not rst_i. It is combinational from the registered level only, with no path from the pop.
- Push happens on s_valid_i and s_ready_o at a clock edge. Data is held unchanged in the FIFO; order is strictly FIFO.
- Pop and push in the same cycle: level is unchanged.
- No write-through bypass: a sample pushed in cycle n is poppable no earlier than cycle n+1.
- State machine, 2 states:
  - IDLE: hold counter forced to 0; bb_data_o=0; no pops. The FIFO keeps its contents and still accepts pushes. Go to RUN when enable_i=1.
  - RUN: go to IDLE when enable_i=0; at that same edge bb_data_o<=0 and the counter is cleared.
- Boundary: the state is RUN, enable_i=1 and counter==0. At a boundary:
  - counter <= hold_cycles_i, sampled only here.
  - If FIFO not empty: pop; bb_data_o <= head; last-sample register <= head; sample_strobe_o=1 next cycle.
  - If FIFO empty: underflow_o<=1; sample_strobe_o=0; bb_data_o <= 0 when UNDERFLOW_HOLD=0, or last sample when UNDERFLOW_HOLD=1.
- Off a boundary in RUN: counter decrements; bb_data_o holds; sample_strobe_o=0.
- Sample period is hold_cycles_i+1 clocks. hold_cycles_i=0 gives one sample per clock.
- A hold_cycles_i change mid-period takes effect at the next boundary.
- Latency: enable_i sampled high at edge k puts the state in RUN. The first boundary is at edge k+1, where bb_data_o and sample_strobe_o update.
- underflow_o is set only by a boundary on an empty FIFO. If underflow_clr_i and a set occur in the same cycle, set wins.
- fifo_level_o never exceeds 2**FIFO_AW and never wraps below 0. Read and write pointers are FIFO_AW bits and wrap modulo depth.
- Reset asserted mid-operation discards FIFO contents and returns every output to its reset value asynchronously.

Test Plan:
- Reset, then push 3 samples 0x10,0x20,0x30 with enable=0 -> s_ready_o=1, fifo_level_o=3, bb_data_o=0, no strobes.
- Enable with hold_cycles_i=3 -> bb_data_o=0x10,0x20,0x30 each held 4 clocks; strobe on each change; then underflow_o=1 and bb_data_o=0.
- Same run with UNDERFLOW_HOLD=1 -> after 0x30, bb_data_o stays 0x30 and underflow_o=1; pulse underflow_clr_i -> underflow_o=0 if no boundary occurs that cycle.
- Push 17 samples continuously with enable=0 -> 16 accepted, s_ready_o=0 from level 16, the 17th is held by the source; enable with hold=0 -> one pop per clock, s_ready_o returns high, output order preserved.
- hold_cycles_i=0, s_valid_i always high, FIFO at level 1 -> simultaneous push/pop keeps level at 1, a strobe every cycle, no underflow.
- Drop enable mid-period, then assert rst_i mid-stream -> IDLE: bb_data_o=0 next edge; reset: fifo_level_o=0, underflow_o=0, all outputs 0 immediately.
